// File: rtl/dtack_gen.sv
// DTACK generator for the 68000 bus glue logic.
// Adds per-device wait states for ROM and RAM selects and passes the DUART DTACK
// straight through to the CPU. Defining BERR_TIMEOUT_EN adds the as_n input, the
// berr output and a bus-error timeout counter.
module dtack_gen #(
  parameter int unsigned ROM_WAIT    = 3,
  parameter int unsigned RAM_WAIT    = 1,
  parameter int unsigned BERR_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic ram_evn_cs,
  input  logic ram_odd_cs,
  input  logic rom_evn_cs,
  input  logic rom_odd_cs,
  input  logic duart_dtack,
`ifdef BERR_TIMEOUT_EN
  input  logic as_n,
  output logic berr,
`endif
  output logic dtack
);

  localparam logic [3:0] RomWait  = 4'(ROM_WAIT);
  localparam logic [3:0] RamWait  = 4'(RAM_WAIT);
  localparam logic [3:0] CntMax   = 4'hf;

  logic       rom_sel;
  logic       ram_sel;
  logic       mem_sel;
  logic [3:0] wait_n;
  logic [3:0] cnt_d, cnt_q;
  logic       mem_ack;

  // Decode the active-low selects; ROM wins when both are active.
  always_comb begin
    rom_sel = ~rom_evn_cs | ~rom_odd_cs;
    ram_sel = ~ram_evn_cs | ~ram_odd_cs;
    mem_sel = rom_sel | ram_sel;
    wait_n  = rom_sel ? RomWait : RamWait;
  end

  // Wait counter next state: clear between accesses, saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (!mem_sel) begin
      cnt_d = 4'd0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output is combinational on the selects so DTACK never stretches into the next
  // cycle; reset masks the memory path (a zero wait would otherwise ack) but not
  // the unregistered DUART path.
  always_comb begin
    mem_ack = mem_sel & (cnt_q >= wait_n) & ~reset;
    dtack   = ~(mem_ack | ~duart_dtack);
  end

`ifdef BERR_TIMEOUT_EN
  localparam logic [7:0] BerrCycles = 8'(BERR_CYCLES);

  logic [7:0] tmo_d, tmo_q;
  logic       tmo_hit;

  // Timeout counter next state: runs while a strobed cycle goes unacknowledged,
  // stops at the limit so berr holds until the strobe is released.
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = (tmo_q == BerrCycles);
    if (as_n) begin
      tmo_d = 8'd0;
    end else if (dtack && !tmo_hit) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  // Bus error releases as soon as the strobe goes high.
  always_comb begin
    berr = ~(tmo_hit & ~as_n & ~reset);
  end
`endif

endmodule

// File: tb/tb_dtack_gen.sv
// Directed self-checking bench for dtack_gen with default wait states (ROM 3, RAM 1).
module tb_dtack_gen;

  logic clk = 1'b0;
  logic reset;
  logic ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs;
  logic duart_dtack;
  logic dtack;
`ifdef BERR_TIMEOUT_EN
  logic as_n;
  logic berr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dtack_gen dut (
    .clk        (clk),
    .reset      (reset),
    .ram_evn_cs (ram_evn_cs),
    .ram_odd_cs (ram_odd_cs),
    .rom_evn_cs (rom_evn_cs),
    .rom_odd_cs (rom_odd_cs),
    .duart_dtack(duart_dtack),
`ifdef BERR_TIMEOUT_EN
    .as_n       (as_n),
    .berr       (berr),
`endif
    .dtack      (dtack)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where inputs are changed.
  task automatic to_neg();
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    ram_evn_cs  = 1'b1;
    ram_odd_cs  = 1'b1;
    rom_evn_cs  = 1'b1;
    rom_odd_cs  = 1'b1;
    duart_dtack = 1'b1;
`ifdef BERR_TIMEOUT_EN
    as_n        = 1'b1;
`endif

    // Reset state and release.
    #2;
    check_bit("rst_dtack", dtack, 1'b1);
    tick();
    check_bit("rst_dtack_edge", dtack, 1'b1);
    to_neg();
    reset = 1'b0;
    #1 check_bit("rel_dtack", dtack, 1'b1);
    tick();
    check_bit("idle_dtack", dtack, 1'b1);

    // ROM even select: acks after the third edge, releases immediately.
    to_neg();
    rom_evn_cs = 1'b0;
    #1 check_bit("rom_e0", dtack, 1'b1);
    tick(); check_bit("rom_e1", dtack, 1'b1);
    tick(); check_bit("rom_e2", dtack, 1'b1);
    tick(); check_bit("rom_e3", dtack, 1'b0);
    tick(); check_bit("rom_e4", dtack, 1'b0);
    to_neg();
    rom_evn_cs = 1'b1;
    #1 check_bit("rom_release", dtack, 1'b1);

    // ROM odd, then RAM even and RAM odd, each separated by a one-clock gap.
    to_neg();
    rom_odd_cs = 1'b0;
    tick(); check_bit("romo_e1", dtack, 1'b1);
    tick(); check_bit("romo_e2", dtack, 1'b1);
    tick(); check_bit("romo_e3", dtack, 1'b0);
    to_neg();
    rom_odd_cs = 1'b1;
    #1 check_bit("gap1", dtack, 1'b1);
    to_neg();
    ram_evn_cs = 1'b0;
    #1 check_bit("rame_e0", dtack, 1'b1);
    tick(); check_bit("rame_e1", dtack, 1'b0);
    tick(); check_bit("rame_e2", dtack, 1'b0);
    to_neg();
    ram_evn_cs = 1'b1;
    #1 check_bit("gap2", dtack, 1'b1);
    to_neg();
    ram_odd_cs = 1'b0;
    #1 check_bit("ramo_e0", dtack, 1'b1);
    tick(); check_bit("ramo_e1", dtack, 1'b0);
    to_neg();
    ram_odd_cs = 1'b1;
    #1 check_bit("gap3", dtack, 1'b1);

    // ROM and RAM selected together: the ROM wait applies.
    to_neg();
    rom_evn_cs = 1'b0;
    ram_evn_cs = 1'b0;
    tick(); check_bit("fault_e1", dtack, 1'b1);
    tick(); check_bit("fault_e2", dtack, 1'b1);
    tick(); check_bit("fault_e3", dtack, 1'b0);
    to_neg();
    rom_evn_cs = 1'b1;
    ram_evn_cs = 1'b1;
    #1 check_bit("fault_release", dtack, 1'b1);

    // DUART DTACK passes through combinationally.
    to_neg();
    duart_dtack = 1'b0;
    #1 check_bit("duart_low", dtack, 1'b0);
    tick(); check_bit("duart_hold", dtack, 1'b0);
    #3 duart_dtack = 1'b1;
    #1 check_bit("duart_high", dtack, 1'b1);

    // Reset mid-access forces dtack high; counting restarts after release.
    to_neg();
    rom_evn_cs = 1'b0;
    tick(); tick(); tick();
    check_bit("pre_rst_ack", dtack, 1'b0);
    #2 reset = 1'b1;
    #1 check_bit("rst_mid", dtack, 1'b1);
    duart_dtack = 1'b0;
    #1 check_bit("rst_duart", dtack, 1'b0);
    duart_dtack = 1'b1;
    to_neg();
    reset = 1'b0;
    #1 check_bit("rel_sel_e0", dtack, 1'b1);
    tick(); check_bit("rel_sel_e1", dtack, 1'b1);
    tick(); check_bit("rel_sel_e2", dtack, 1'b1);
    tick(); check_bit("rel_sel_e3", dtack, 1'b0);

    // Long select: counter saturates, ack holds.
    for (int i = 0; i < 20; i++) tick();
    check_bit("saturate", dtack, 1'b0);
    to_neg();
    rom_evn_cs = 1'b1;
    #1 check_bit("sat_release", dtack, 1'b1);

`ifdef BERR_TIMEOUT_EN
    // Unacknowledged strobe: bus error after 64 clocks, cleared by as_n high.
    to_neg();
    as_n = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    check_bit("berr_63", berr, 1'b1);
    tick();
    check_bit("berr_64", berr, 1'b0);
    tick();
    check_bit("berr_hold", berr, 1'b0);
    to_neg();
    as_n = 1'b1;
    #1 check_bit("berr_clear", berr, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
